// File: rtl/pwm_sample_feeder.sv
// Stereo sample FIFO that hands one left/right duty pair to a PWM output stage per frame.
// An empty FIFO at the end of a frame holds the previous duty values and records an underrun.
module pwm_sample_feeder #(
    parameter int PERIOD = 256,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     aclr_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_left,
    input  logic [7:0]               in_right,
    output logic                     in_ready,
    output logic [7:0]               left_top,
    output logic [7:0]               right_top,
    output logic                     frame_strobe,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     underrun,
    output logic [7:0]               underrun_count
);

    localparam int CW = $clog2(PERIOD);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [7:0]    left_q, left_d;
    logic [7:0]    right_q, right_d;
    logic          strobe_q, strobe_d;
    logic          under_q, under_d;
    logic [7:0]    ucnt_q, ucnt_d;
    logic [15:0]   mem [DEPTH];

    logic pop_cycle;
    logic push;
    logic pop;

    // Ready depends only on registered occupancy, so a full FIFO refuses a push even while popping.
    assign in_ready = (fill_q < FULL);

    always_comb begin
        pop_cycle = (cnt_q == CNT_LAST);
        push      = in_valid && in_ready;
        pop       = pop_cycle && (fill_q != '0);

        cnt_d    = pop_cycle ? '0 : cnt_q + CW'(1);
        wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d   = pop ? rptr_q + AW'(1) : rptr_q;
        fill_d   = fill_q;
        left_d   = left_q;
        right_d  = right_q;
        strobe_d = pop;
        under_d  = under_q;
        ucnt_d   = ucnt_q;

        case ({push, pop})
            2'b10:   fill_d = fill_q + (AW + 1)'(1);
            2'b01:   fill_d = fill_q - (AW + 1)'(1);
            default: fill_d = fill_q;
        endcase

        if (pop) begin
            left_d  = mem[rptr_q][15:8];
            right_d = mem[rptr_q][7:0];
        end

        // A push landing in the same cycle cannot rescue an empty pop cycle.
        if (pop_cycle && (fill_q == '0)) begin
            under_d = 1'b1;
            if (ucnt_q != 8'hFF) begin
                ucnt_d = ucnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fill_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            strobe_q <= 1'b0;
            under_q  <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fill_q   <= fill_d;
            left_q   <= left_d;
            right_q  <= right_d;
            strobe_q <= strobe_d;
            under_q  <= under_d;
            ucnt_q   <= ucnt_d;
        end
    end

    // Storage is not reset; pointers and occupancy alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {in_left, in_right};
        end
    end

    assign left_top       = left_q;
    assign right_top      = right_q;
    assign frame_strobe   = strobe_q;
    assign fill           = fill_q;
    assign underrun       = under_q;
    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Bench for pwm_sample_feeder: queue-based frame model checked every cycle plus directed literal checks.
module tb_pwm_sample_feeder;

    localparam int PERIOD = 16;
    localparam int DEPTH  = 4;

    logic       clk;
    logic       aclr_n;
    logic       in_valid;
    logic [7:0] in_left;
    logic [7:0] in_right;
    logic       in_ready;
    logic [7:0] left_top;
    logic [7:0] right_top;
    logic       frame_strobe;
    logic [2:0] fill;
    logic       underrun;
    logic [7:0] underrun_count;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_sample_feeder #(.PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .aclr_n         (aclr_n),
        .in_valid       (in_valid),
        .in_left        (in_left),
        .in_right       (in_right),
        .in_ready       (in_ready),
        .left_top       (left_top),
        .right_top      (right_top),
        .frame_strobe   (frame_strobe),
        .fill           (fill),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: time since reset, a queue of pending samples, frame boundary every PERIOD clocks
    int          m_t;
    logic [15:0] m_q[$];
    logic [15:0] m_e;
    int          m_left, m_right, m_strobe, m_under, m_ucnt;
    bit          m_pc, m_acc;

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            m_t = 0; m_q.delete();
            m_left = 0; m_right = 0; m_strobe = 0; m_under = 0; m_ucnt = 0;
        end else begin
            m_pc  = (m_t % PERIOD) == PERIOD - 1;
            m_acc = in_valid && (m_q.size() < DEPTH);
            m_strobe = 0;
            if (m_pc) begin
                if (m_q.size() > 0) begin
                    m_e = m_q.pop_front();
                    m_left = int'(m_e[15:8]); m_right = int'(m_e[7:0]); m_strobe = 1;
                end else begin
                    m_under = 1;
                    if (m_ucnt < 255) m_ucnt++;
                end
            end
            if (m_acc) m_q.push_back({in_left, in_right});
            m_t++;
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        check("fill", int'(fill), m_q.size());
        check("in_ready", int'(in_ready), int'(m_q.size() < DEPTH));
        check("left_top", int'(left_top), m_left);
        check("right_top", int'(right_top), m_right);
        check("frame_strobe", int'(frame_strobe), m_strobe);
        check("underrun", int'(underrun), m_under);
        check("underrun_count", int'(underrun_count), m_ucnt);
    end

    // driver tasks
    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        #2 aclr_n = 1'b0;
        @(negedge clk);
        aclr_n = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] l, input logic [7:0] r);
        in_valid = 1'b1; in_left = l; in_right = r;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_strobe(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (frame_strobe) seen = 1'b1;
        end
        check("strobe_wait", int'(seen), 1);
    endtask

    initial begin
        int v, acc, strobes;
        bit rdy;
        aclr_n = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
        repeat (2) @(negedge clk);
        check("rst_fill", int'(fill), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_left", int'(left_top), 0);
        check("rst_ucnt", int'(underrun_count), 0);
        aclr_n = 1'b1;

        // three empty frames
        idle(3 * PERIOD);
        check("idle_left", int'(left_top), 0);
        check("idle_right", int'(right_top), 0);
        check("idle_underrun", int'(underrun), 1);
        check("idle_ucnt", int'(underrun_count), 3);

        // two back-to-back pushes
        do_reset();
        push(8'd127, 8'd0);
        push(8'd0, 8'd127);
        check("b2b_fill", int'(fill), 2);
        wait_strobe(2 * PERIOD);
        check("b2b_left1", int'(left_top), 127);
        check("b2b_right1", int'(right_top), 0);
        @(negedge clk);
        check("b2b_strobe_1cyc", int'(frame_strobe), 0);
        wait_strobe(2 * PERIOD);
        check("b2b_left2", int'(left_top), 0);
        check("b2b_right2", int'(right_top), 127);
        check("b2b_underrun", int'(underrun), 0);

        // continuous valid with incrementing samples
        do_reset();
        v = 1; acc = 0;
        in_valid = 1'b1; in_left = 8'(v); in_right = ~8'(v);
        for (int i = 0; i < 8 * PERIOD; i++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) begin acc++; v++; end
            in_left = 8'(v); in_right = ~8'(v);
            if (i == DEPTH - 1) check("stream_full_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        check("stream_accepts", acc, 11);
        check("stream_left", int'(left_top), 8);
        check("stream_right", int'(right_top), 247);

        // push exactly in an empty pop cycle
        do_reset();
        idle(PERIOD - 1);
        push(8'd55, 8'd66);
        check("popcyc_ucnt", int'(underrun_count), 1);
        check("popcyc_fill", int'(fill), 1);
        check("popcyc_strobe", int'(frame_strobe), 0);
        wait_strobe(2 * PERIOD);
        check("popcyc_left", int'(left_top), 55);
        check("popcyc_right", int'(right_top), 66);

        // mid-frame reset with a full FIFO and non-zero outputs
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(8'(10 + i), 8'(20 + i));
        idle(PERIOD);
        check("pre_rst_left", int'(left_top), 10);
        @(negedge clk);
        #2 aclr_n = 1'b0;
        #1;
        check("async_left", int'(left_top), 0);
        check("async_right", int'(right_top), 0);
        check("async_fill", int'(fill), 0);
        check("async_ready", int'(in_ready), 1);
        check("async_strobe", int'(frame_strobe), 0);
        check("async_ucnt", int'(underrun_count), 0);
        @(negedge clk);
        aclr_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if (frame_strobe) strobes++;
        end
        check("post_rst_strobes", strobes, 0);
        check("post_rst_ucnt", int'(underrun_count), 2);
        push(8'd99, 8'd11);
        wait_strobe(2 * PERIOD);
        check("post_rst_left", int'(left_top), 99);

        // saturation of the underrun counter
        do_reset();
        idle(300 * PERIOD);
        check("sat_ucnt", int'(underrun_count), 255);
        check("sat_underrun", int'(underrun), 1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
